// File: rtl/prog_sequencer.sv
// Host-side Start/Ack run controller: launches NPROG programs per Go request,
// times each run against MAX_CYC and reports per-program and total cycle counts.
module prog_sequencer #(
  parameter int unsigned     NPROG     = 3,
  parameter int unsigned     START_CYC = 2,
  parameter int unsigned     GAP_CYC   = 1,
  parameter int unsigned     CW        = 16,
  parameter logic [CW-1:0]   MAX_CYC   = {CW{1'b1}}
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Go,
  input  logic          Abort,
  input  logic          Ack,
  output logic          Start,
  output logic          Busy,
  output logic [3:0]    ProgIdx,
  output logic          ProgDone,
  output logic [CW-1:0] CycleCount,
  output logic [CW-1:0] TotalCycles,
  output logic          TimedOut,
  output logic          AllDone
);

  localparam int unsigned     PMAX       = (START_CYC > GAP_CYC) ? START_CYC : GAP_CYC;
  localparam int unsigned     PW         = (PMAX < 2) ? 1 : $clog2(PMAX);
  localparam logic [PW-1:0]   START_LAST = PW'(START_CYC - 1);
  localparam logic [PW-1:0]   GAP_LAST   = PW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [3:0]      LAST_IDX   = 4'(NPROG - 1);
  localparam logic [CW-1:0]   MAX_M1     = MAX_CYC - CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_REPORT, S_GAP, S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [CW-1:0] tot_q, tot_d;
  logic [3:0]    idx_q, idx_d;
  logic          to_q, to_d;
  logic          done_q, done_d;
  logic          start_q, start_d;
  logic [CW:0]   sum;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      run_q   <= '0;
      cc_q    <= '0;
      tot_q   <= '0;
      idx_q   <= '0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      cc_q    <= cc_d;
      tot_q   <= tot_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  // NOTE: every variable gets a default first so this block infers no latches.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    run_d   = run_q;
    cc_d    = cc_q;
    tot_d   = tot_q;
    idx_d   = idx_q;
    to_d    = to_q;
    done_d  = done_q;
    sum     = {1'b0, tot_q} + {1'b0, cc_q};

    if (Abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Go) begin
            state_d = S_START;
            phase_d = '0;
            run_d   = '0;
            idx_d   = '0;
            tot_d   = '0;
            to_d    = 1'b0;
            done_d  = 1'b0;
          end
        end
        S_START: begin
          // Ack is deliberately ignored here: it may still be high from the last halt.
          if (phase_q == START_LAST) begin
            state_d = S_RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_RUN: begin
          if (Ack) begin
            state_d = S_REPORT;
            cc_d    = run_q;
          end else if (run_q == MAX_M1) begin
            state_d = S_REPORT;
            cc_d    = MAX_CYC;
            to_d    = 1'b1;
          end else begin
            run_d = run_q + CW'(1);
          end
        end
        S_REPORT: begin
          tot_d = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
          if (to_q || idx_q == LAST_IDX) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = (GAP_CYC == 0) ? S_START : S_GAP;
            idx_d   = idx_q + 4'd1;
            run_d   = '0;
            phase_d = '0;
          end
        end
        S_GAP: begin
          if (phase_q == GAP_LAST) begin
            state_d = S_START;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_FINISH: begin
          if (!Go) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_d     = (state_d == S_START);
    Start       = start_q;
    Busy        = (state_q != S_IDLE);
    ProgDone    = (state_q == S_REPORT);
    ProgIdx     = idx_q;
    CycleCount  = cc_q;
    TotalCycles = tot_q;
    TimedOut    = to_q;
    AllDone     = done_q;
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a processor model answers Start with Ack
// after chosen delays; expected reports come from a run-length model per Go.
module tb_prog_sequencer;

  typedef struct { int idx; int cc; int to; } done_t;
  typedef struct { int idx; int total; int to; } fin_t;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  logic        go_s[2], abort_s[2], ack_s[2];
  logic        start_s[2], busy_s[2], pd_s[2], to_s[2], ad_s[2];
  logic [3:0]  idx_s[2];
  logic [15:0] cc_s[2], tot_s[2];
  logic [3:0]  cc_b, tot_b;

  assign cc_s[1]  = {12'h000, cc_b};
  assign tot_s[1] = {12'h000, tot_b};

  // Instance 0: nominal sequencing with a short timeout; instance 1: narrow counters.
  prog_sequencer #(.NPROG(3), .START_CYC(2), .GAP_CYC(1), .CW(16), .MAX_CYC(16'd30)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Go(go_s[0]), .Abort(abort_s[0]), .Ack(ack_s[0]),
    .Start(start_s[0]), .Busy(busy_s[0]), .ProgIdx(idx_s[0]), .ProgDone(pd_s[0]),
    .CycleCount(cc_s[0]), .TotalCycles(tot_s[0]), .TimedOut(to_s[0]), .AllDone(ad_s[0]));

  prog_sequencer #(.NPROG(3), .START_CYC(1), .GAP_CYC(0), .CW(4), .MAX_CYC(4'd15)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Go(go_s[1]), .Abort(abort_s[1]), .Ack(ack_s[1]),
    .Start(start_s[1]), .Busy(busy_s[1]), .ProgIdx(idx_s[1]), .ProgDone(pd_s[1]),
    .CycleCount(cc_b), .TotalCycles(tot_b), .TimedOut(to_s[1]), .AllDone(ad_s[1]));

  int max_c[2] = '{30, 15};
  int cap_c[2] = '{65535, 15};
  int st_c[2]  = '{2, 1};
  int gap_c[2] = '{1, 0};

  done_t exp_q[2][$];
  fin_t  fin_q[2][$];
  int    drv_q[2][$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: each program reports min(delay, MAX); a delay >= MAX is a
  // timeout that ends the sequence; the total saturates at the counter range.
  task automatic plan(input int w, input int d0, input int d1, input int d2);
    int d[3];
    int total;
    d = '{d0, d1, d2};
    total = 0;
    drv_q[w].delete();
    for (int i = 0; i < 3; i++) drv_q[w].push_back(d[i]);
    for (int i = 0; i < 3; i++) begin
      int t;
      int c;
      t = (d[i] >= max_c[w]) ? 1 : 0;
      c = t ? max_c[w] : d[i];
      exp_q[w].push_back('{i, c, t});
      total = ((total + c) > cap_c[w]) ? cap_c[w] : (total + c);
      if (t == 1 || i == 2) begin
        fin_q[w].push_back('{i, total, t});
        break;
      end
    end
  endtask

  // Processor model: after Start falls, hold Ack low for d RUN cycles, then pulse it.
  // Outside a run Ack toggles randomly, which the sequencer must ignore.
  initial begin
    bit ps[2];
    bit act[2];
    int k[2];
    int d[2];
    for (int w = 0; w < 2; w++) begin
      ack_s[w] = 1'b0; ps[w] = 1'b0; act[w] = 1'b0; k[w] = 0; d[w] = 0;
    end
    forever begin
      @(negedge Clk);
      for (int w = 0; w < 2; w++) begin
        if (ps[w] && !start_s[w]) begin
          act[w] = 1'b1;
          k[w]   = 0;
          d[w]   = (drv_q[w].size() > 0) ? drv_q[w].pop_front() : 100000;
        end
        ps[w] = start_s[w];
        if (act[w]) begin
          ack_s[w] = (k[w] == d[w]);
          if (k[w] == d[w]) act[w] = 1'b0;
          k[w]++;
        end else begin
          ack_s[w] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: pops expected reports on ProgDone and on the AllDone rising edge,
  // and measures Start width and report-to-Start spacing.
  initial begin
    int sw[2];
    int gc[2];
    bit gp[2];
    bit pa[2];
    done_t e;
    fin_t  f;
    for (int w = 0; w < 2; w++) begin
      sw[w] = 0; gc[w] = 0; gp[w] = 1'b0; pa[w] = 1'b0;
    end
    forever begin
      @(negedge Clk);
      for (int w = 0; w < 2; w++) begin
        if (!Reset_n) begin
          sw[w] = 0; gp[w] = 1'b0; pa[w] = 1'b0;
        end else begin
          if (pd_s[w]) begin
            check("busy_at_progdone", busy_s[w], 1);
            if (exp_q[w].size() == 0) begin
              check("unexpected_progdone", pd_s[w], 0);
            end else begin
              e = exp_q[w].pop_front();
              check("progdone_idx", idx_s[w], e.idx);
              check("progdone_cycles", cc_s[w], e.cc);
              check("progdone_timedout", to_s[w], e.to);
            end
            gp[w] = 1'b1;
            gc[w] = 0;
          end else if (gp[w]) begin
            gc[w]++;
            if (start_s[w]) begin
              check("gap_to_start", gc[w], gap_c[w] + 1);
              gp[w] = 1'b0;
            end else if (!busy_s[w] || ad_s[w]) begin
              gp[w] = 1'b0;
            end
          end
          if (start_s[w]) sw[w]++;
          else if (sw[w] > 0) begin
            check("start_width", sw[w], st_c[w]);
            sw[w] = 0;
          end
          if (ad_s[w] && !pa[w]) begin
            if (fin_q[w].size() == 0) begin
              check("unexpected_alldone", ad_s[w], 0);
            end else begin
              f = fin_q[w].pop_front();
              check("final_total", tot_s[w], f.total);
              check("final_timedout", to_s[w], f.to);
              check("final_idx", idx_s[w], f.idx);
            end
          end
          pa[w] = ad_s[w];
        end
      end
    end
  end

  task automatic run_go(input int w, input int d0, input int d1, input int d2, input bit hold);
    plan(w, d0, d1, d2);
    go_s[w] = 1'b1;
    @(negedge Clk);
    check("go_start", start_s[w], 1);
    check("go_busy", busy_s[w], 1);
    if (!hold) go_s[w] = 1'b0;
    for (int i = 0; i < 3000 && !ad_s[w]; i++) @(negedge Clk);
    check("alldone_seen", ad_s[w], 1);
    if (hold) begin
      repeat (2) @(negedge Clk);
      check("finish_holds_busy", busy_s[w], 1);
      go_s[w] = 1'b0;
    end
    @(negedge Clk);
    check("back_to_idle", busy_s[w], 0);
    check("alldone_sticky", ad_s[w], 1);
    check("reports_drained", exp_q[w].size() + fin_q[w].size(), 0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    Reset_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      go_s[w] = 1'b0; abort_s[w] = 1'b0;
    end
    repeat (3) @(negedge Clk);
    for (int w = 0; w < 2; w++) begin
      check("rst_start", start_s[w], 0);
      check("rst_busy", busy_s[w], 0);
      check("rst_outputs", {idx_s[w], pd_s[w], cc_s[w], tot_s[w], to_s[w], ad_s[w]}, 0);
    end
    Reset_n = 1'b1;
    @(negedge Clk);

    // Nominal, boundary delays (0 and MAX-1), and timeouts on programs 1 and 0.
    run_go(0, 10, 25, 7, 1'b1);
    run_go(0, 0, 5, 29, 1'b0);
    run_go(0, 3, 30, 4, 1'b0);
    run_go(0, 30, 1, 1, 1'b0);
    repeat (6) run_go(0, int'($urandom_range(0, 34)), int'($urandom_range(0, 34)),
                      int'($urandom_range(0, 34)), 1'b0);

    // Abort on the third RUN cycle of program 0.
    drv_q[0].delete();
    drv_q[0].push_back(100000);
    go_s[0] = 1'b1;
    @(negedge Clk);
    go_s[0] = 1'b0;
    for (int i = 0; i < 50 && start_s[0]; i++) @(negedge Clk);
    repeat (2) @(negedge Clk);
    check("abort_pre_busy", busy_s[0], 1);
    abort_s[0] = 1'b1;
    @(negedge Clk);
    abort_s[0] = 1'b0;
    check("abort_busy", busy_s[0], 0);
    check("abort_start", start_s[0], 0);
    check("abort_alldone", ad_s[0], 0);
    check("abort_progdone", pd_s[0], 0);
    check("abort_idx", idx_s[0], 0);
    @(negedge Clk);
    check("abort_stays_idle", busy_s[0], 0);
    run_go(0, 4, 4, 4, 1'b0);

    // Abort and Go together in IDLE: Abort wins.
    go_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge Clk);
    go_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check("abort_go_busy", busy_s[0], 0);
    check("abort_go_start", start_s[0], 0);
    @(negedge Clk);
    check("abort_go_idle", busy_s[0], 0);

    // Asynchronous reset mid-START, between clock edges.
    drv_q[0].delete();
    go_s[0] = 1'b1;
    @(negedge Clk);
    go_s[0] = 1'b0;
    check("pre_reset_start", start_s[0], 1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_start", start_s[0], 0);
    check("async_rst_busy", busy_s[0], 0);
    check("async_rst_outputs", {idx_s[0], pd_s[0], cc_s[0], tot_s[0], to_s[0], ad_s[0]}, 0);
    @(negedge Clk);
    #3 Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("post_reset_idle", busy_s[0], 0);
    check("post_reset_start", start_s[0], 0);
    run_go(0, 12, 0, 3, 1'b0);

    // Narrow counters: saturation of the total and an exact-MAX timeout.
    run_go(1, 6, 7, 8, 1'b0);
    run_go(1, 15, 1, 1, 1'b0);
    run_go(1, 14, 14, 14, 1'b0);
    repeat (4) run_go(1, int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
                      int'($urandom_range(0, 16)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
